draw_sequencer: RTL
===================

// Module: draw_sequencer
// PURPOSE
// - Parametrised frame pacer + draw-channel sequencer between control FSM and VGA adapter.
// - Generates the frame tick, then grants NUM_SRC sprite/map drawers in index order (0 = map first).
// - Start/done handshake per channel; registered VGA output mux; transparent-colour write suppression.
// - Sticky overrun flag and counter for late frames.
// PARAMETERS
// NUM_SRC      3        number of draw channels, 1..8
// X_W          9        VGA x coordinate width
// Y_W          8        VGA y coordinate width
// COLOUR_W     6        colour width
// FRAME_COUNT  1666666  clocks per frame (50 MHz / 30 fps), >= 2
// CNT_W        24       frame counter width, 2^CNT_W > FRAME_COUNT
// TRANSPARENT  6'h3F    colour value never written to VGA
// PORTS
// clock        in   1                  system clock, CLOCK_50
// reset        in   1                  synchronous, active-high
// run          in   1                  level; 1 = sequence a frame on each tick
// src_mask     in   NUM_SRC            1 = channel drawn this frame; sampled at tick
// src_done     in   NUM_SRC            per-channel draw complete (level or pulse)
// src_write    in   NUM_SRC            per-channel pixel valid
// src_x        in   NUM_SRC*X_W        packed, channel i at [i*X_W +: X_W]
// src_y        in   NUM_SRC*Y_W        packed likewise
// src_colour   in   NUM_SRC*COLOUR_W   packed likewise
// src_enable   out  NUM_SRC            one-hot grant, drawer runs while high
// x_position   out  X_W                registered VGA x
// y_position   out  Y_W                registered VGA y
// colour       out  COLOUR_W           registered VGA colour
// VGA_enable   out  1                  registered VGA write enable
// frame_tick   out  1                  1-cycle pulse every FRAME_COUNT clocks
// frame_done   out  1                  1-cycle pulse, all masked channels drawn
// busy         out  1                  high from tick accept to frame_done
// overrun      out  1                  sticky: tick arrived while busy
// overrun_cnt  out  8                  saturating count of overruns
// BEHAVIOUR
// - Reset: all outputs 0, counter 0, FSM IDLE, mask latch 0. Reset mid-frame aborts immediately.
// - Frame counter: free-running 0..FRAME_COUNT-1, wraps to 0; frame_tick high when count==FRAME_COUNT-1.
//   Counter runs regardless of run/busy.
// - FSM: IDLE -> SEL on frame_tick&run (latch src_mask, idx=0).
//   SEL: advance idx to lowest latched-mask bit >= idx; none left -> DONE; found -> DRAW.
//   DRAW: src_enable[idx]=1. src_done[idx]=1 -> GAP. Other channels' done ignored.
//   GAP: 1 cycle all enables 0 (drawer clears its done); idx+1 -> SEL.
//   DONE: frame_done=1 for one cycle -> IDLE.
// - Empty mask: tick -> SEL -> DONE; frame_done exactly 2 cycles after tick.
// - busy = state != IDLE. Tick while busy: no restart, overrun<=1, overrun_cnt+1 saturating at 255.
//   Only reset clears overrun/overrun_cnt.
// - run dropped mid-frame: current frame completes; no new frame starts.
// - VGA mux, 1-cycle latency: in DRAW, outputs <= channel idx fields;
//   VGA_enable <= src_write[idx] & (src_colour[idx] != TRANSPARENT).
//   Outside DRAW: x/y/colour/VGA_enable <= 0.
// - src_done[idx] already high on DRAW entry: DRAW lasts 1 cycle; that cycle's pixel still forwarded.
// - src_enable is registered with the state, zero-glitch, never more than one bit high.
// STRUCTURE
// - Shared package draw_pkg: state encoding (IDLE,SEL,DRAW,GAP,DONE), ON/OFF, default FRAME_COUNT, colour widths.
// - Sub-module frame_timer (counter + tick, params FRAME_COUNT, CNT_W); sequencer FSM and mux stay in top.
// - Index width $clog2(NUM_SRC) with minimum 1.
// TESTING (bench: FRAME_COUNT=20, NUM_SRC=3)
// - Reset release, run=1, mask=3'b111, each drawer done after 4 pixels -> enables 001,010,100 in order,
//   1 GAP cycle between each, 12 VGA writes, frame_done once.
// - mask=3'b101 -> channel 1 never enabled; order 0 then 2.
// - Channel 1 writes colour 6'h3F then 6'h05 -> only the 6'h05 pixel has VGA_enable=1, one cycle after input.
// - Channel 0 holds done low for 30 cycles -> overrun=1, overrun_cnt=1; no restart; next frame at following tick.
// - mask=0 -> frame_done 2 cycles after frame_tick; no enable ever high.
// - reset asserted during DRAW -> next cycle all outputs 0, FSM IDLE; first frame_tick 20 cycles after release.

Source files
------------

// File: rtl/draw_sequencer_pkg.sv
// Shared definitions for the draw sequencer: FSM state encoding, ON/OFF levels,
// default frame timing and VGA field widths.
package draw_pkg;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    // 50 MHz / 30 fps
    localparam int unsigned DEF_FRAME_COUNT = 1666666;
    localparam int unsigned DEF_CNT_W       = 24;

    localparam int unsigned DEF_NUM_SRC  = 3;
    localparam int unsigned DEF_X_W      = 9;
    localparam int unsigned DEF_Y_W      = 8;
    localparam int unsigned DEF_COLOUR_W = 6;

    localparam logic [DEF_COLOUR_W-1:0] DEF_TRANSPARENT = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_DRAW,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    // Channel index width; a single channel still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// Bundle of draw-channel handshakes, VGA write port and frame status.
// master: the sequencer; slave: control FSM, drawers and VGA adapter.
interface draw_sequencer_if #(
    parameter int unsigned NUM_SRC  = 3,
    parameter int unsigned X_W      = 9,
    parameter int unsigned Y_W      = 8,
    parameter int unsigned COLOUR_W = 6
);

    logic                         run;
    logic [NUM_SRC-1:0]           src_mask;
    logic [NUM_SRC-1:0]           src_done;
    logic [NUM_SRC-1:0]           src_write;
    logic [NUM_SRC*X_W-1:0]       src_x;
    logic [NUM_SRC*Y_W-1:0]       src_y;
    logic [NUM_SRC*COLOUR_W-1:0]  src_colour;
    logic [NUM_SRC-1:0]           src_enable;
    logic [X_W-1:0]               x_position;
    logic [Y_W-1:0]               y_position;
    logic [COLOUR_W-1:0]          colour;
    logic                         VGA_enable;
    logic                         frame_tick;
    logic                         frame_done;
    logic                         busy;
    logic                         overrun;
    logic [7:0]                   overrun_cnt;

    modport master (
        input  run, src_mask, src_done, src_write, src_x, src_y, src_colour,
        output src_enable, x_position, y_position, colour, VGA_enable,
               frame_tick, frame_done, busy, overrun, overrun_cnt
    );

    modport slave (
        output run, src_mask, src_done, src_write, src_x, src_y, src_colour,
        input  src_enable, x_position, y_position, colour, VGA_enable,
               frame_tick, frame_done, busy, overrun, overrun_cnt
    );

endinterface

// File: rtl/draw_sequencer_frame_timer.sv
// Free-running frame pacer: counts 0..FRAME_COUNT-1 and flags the last count.
module frame_timer
    import draw_pkg::*;
#(
    parameter int unsigned FRAME_COUNT = DEF_FRAME_COUNT,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_COUNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap to zero after the last count of the frame.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // Counter register, independent of sequencer activity.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/draw_sequencer.sv
// Frame pacer plus draw-channel sequencer: on each frame tick grants the masked
// drawers one at a time in index order and muxes the granted drawer onto the
// registered VGA write port, dropping transparent pixels.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int unsigned NUM_SRC     = DEF_NUM_SRC,
    parameter int unsigned X_W         = DEF_X_W,
    parameter int unsigned Y_W         = DEF_Y_W,
    parameter int unsigned COLOUR_W    = DEF_COLOUR_W,
    parameter int unsigned FRAME_COUNT = DEF_FRAME_COUNT,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = COLOUR_W'(DEF_TRANSPARENT)
) (
    input  logic              clock,
    input  logic              reset,
    draw_sequencer_if.master  bus
);

    localparam int unsigned IDX_W = idx_width(NUM_SRC);
    // The scan cursor carries one spare bit so that stepping past the last
    // channel cannot wrap back to channel 0 when NUM_SRC is a power of two.
    localparam int unsigned CUR_W = IDX_W + 1;

    logic tick;

    seq_state_e          state_q, state_d;
    logic [CUR_W-1:0]    cur_q,   cur_d;
    logic [NUM_SRC-1:0]  mask_q,  mask_d;
    logic [NUM_SRC-1:0]  en_q,    en_d;
    logic                ovr_q,   ovr_d;
    logic [7:0]          ovc_q,   ovc_d;
    logic [X_W-1:0]      x_q,     x_d;
    logic [Y_W-1:0]      y_q,     y_d;
    logic [COLOUR_W-1:0] col_q,   col_d;
    logic                we_q,    we_d;

    logic [IDX_W-1:0]    idx;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;

    frame_timer #(
        .FRAME_COUNT (FRAME_COUNT),
        .CNT_W       (CNT_W)
    ) u_frame_timer (
        .clk_i  (clock),
        .rst_i  (reset),
        .tick_o (tick)
    );

    assign idx = cur_q[IDX_W-1:0];

    // Lowest latched-mask channel at or above the scan cursor.
    always_comb begin
        sel_found = OFF;
        sel_idx   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!sel_found && mask_q[i] && (i >= 32'(cur_q))) begin
                sel_found = ON;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Sequencer next state, grant vector and overrun bookkeeping.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        mask_d  = mask_q;
        en_d    = en_q;
        ovr_d   = ovr_q;
        ovc_d   = ovc_q;

        case (state_q)
            ST_IDLE: begin
                if (tick && bus.run) begin
                    state_d = ST_SEL;
                    mask_d  = bus.src_mask;
                    cur_d   = '0;
                end
            end
            ST_SEL: begin
                if (sel_found) begin
                    state_d       = ST_DRAW;
                    cur_d         = {1'b0, sel_idx};
                    en_d          = '0;
                    en_d[sel_idx] = ON;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DRAW: begin
                if (bus.src_done[idx]) begin
                    state_d = ST_GAP;
                    en_d    = '0;
                end
            end
            ST_GAP: begin
                state_d = ST_SEL;
                cur_d   = cur_q + CUR_W'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = '0;
            end
        endcase

        if (tick && (state_q != ST_IDLE)) begin
            ovr_d = ON;
            if (ovc_q != 8'hFF) begin
                ovc_d = ovc_q + 8'd1;
            end
        end
    end

    // VGA mux: forward the granted channel, suppress transparent writes.
    always_comb begin
        x_d   = '0;
        y_d   = '0;
        col_d = '0;
        we_d  = OFF;
        if (state_q == ST_DRAW) begin
            x_d   = bus.src_x[idx*X_W +: X_W];
            y_d   = bus.src_y[idx*Y_W +: Y_W];
            col_d = bus.src_colour[idx*COLOUR_W +: COLOUR_W];
            we_d  = bus.src_write[idx] &&
                    (bus.src_colour[idx*COLOUR_W +: COLOUR_W] != TRANSPARENT);
        end
    end

    // State, grant, status and VGA output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            mask_q  <= '0;
            en_q    <= '0;
            ovr_q   <= OFF;
            ovc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            we_q    <= OFF;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            mask_q  <= mask_d;
            en_q    <= en_d;
            ovr_q   <= ovr_d;
            ovc_q   <= ovc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            we_q    <= we_d;
        end
    end

    assign bus.src_enable  = en_q;
    assign bus.x_position  = x_q;
    assign bus.y_position  = y_q;
    assign bus.colour      = col_q;
    assign bus.VGA_enable  = we_q;
    assign bus.frame_tick  = tick;
    assign bus.frame_done  = (state_q == ST_DONE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.overrun     = ovr_q;
    assign bus.overrun_cnt = ovc_q;

endmodule
